lsu_request_engine: RTL and testbench
=====================================

# lsu_request_engine

Consumer end of the load-store request FIFO. Pops one packed request at a time from the FIFO read interface, checks alignment, and issues it to a single-port memory over a req/gnt + rvalid interface. It returns a per-request response (load data, store acknowledge, or error) over a valid/ready handshake. It processes strictly one request in flight, in order.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, request/response data width
- REQ_WIDTH, 1+ADDR_WIDTH+DATA_WIDTH (65), packed request width; bit [REQ_WIDTH-1] is wr (1 = store), next ADDR_WIDTH bits are addr, low DATA_WIDTH bits are wdata
- TIMEOUT, 16, max cycles spent in WAIT before an error response
- CNT_WIDTH, 16, width of completed-transaction counter

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO has no entries
- fifo_rd_data  in  REQ_WIDTH  head-of-FIFO entry, valid combinationally whenever !fifo_empty (show-ahead)
- fifo_rd_en  out  1  pop strobe, one cycle per request
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word-aligned address
- mem_wdata  out  DATA_WIDTH  store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  completion (load data or store ack)
- mem_rdata  in  DATA_WIDTH  load data, qualified by mem_rvalid
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_is_wr  out  1  response belongs to a store
- rsp_data  out  DATA_WIDTH  load data; 0 for stores and errors
- rsp_err  out  1  misaligned address or timeout
- busy  out  1  state != IDLE
- txn_count  out  CNT_WIDTH  responses accepted since reset, wraps

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: when !fifo_empty, assert fifo_rd_en for one cycle and latch wr/addr/wdata from fifo_rd_data in the same cycle. If addr[1:0] != 0, go to RESP with rsp_err=1, rsp_data=0, and no memory access. Otherwise go to ISSUE.
- ISSUE: mem_req=1 with mem_we/mem_addr/mem_wdata driven from the latched registers, all held stable until mem_gnt. On mem_gnt go to WAIT and clear the timeout counter. mem_rvalid is ignored in ISSUE.
- WAIT: mem_req=0. The timeout counter increments each cycle. On mem_rvalid, capture the result and go to RESP: loads take rsp_data=mem_rdata, stores take rsp_data=0, and rsp_err=0. If the counter reaches TIMEOUT-1 without mem_rvalid, go to RESP with rsp_err=1 and rsp_data=0. If mem_rvalid and expiry occur in the same cycle, mem_rvalid wins (no error).
- RESP: rsp_valid=1; rsp_* are held stable while !rsp_ready. When rsp_ready is high, return to IDLE and increment txn_count (mod 2^CNT_WIDTH). No pop occurs in the RESP cycle, so back-to-back requests cost one IDLE cycle each.
- fifo_rd_en is never asserted while fifo_empty=1 or outside IDLE.
- All outputs are registered or decoded from state registers only. There is no combinational path from rsp_ready or mem_gnt to any output.

## Timing
- Reset (synchronous, rst=1 at a clk edge) drives: state=IDLE, fifo_rd_en=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_is_wr=0, rsp_data=0, rsp_err=0, busy=0, txn_count=0.
- Reset mid-operation drops any in-flight request with no response. A late mem_rvalid arriving after reset is ignored in IDLE.
- Minimum latency, with mem_gnt high in ISSUE and mem_rvalid one cycle later:
  - Cycle 0: pop.
  - Cycle 1: mem_req and gnt.
  - Cycle 2: mem_rvalid.
  - Cycle 3: rsp_valid.
- Misaligned request: pop in cycle 0, rsp_valid in cycle 1, no mem_req.
- Timeout: rsp_valid asserts exactly TIMEOUT cycles after the mem_gnt cycle when mem_rvalid never arrives.
- Throughput with rsp_ready tied high and zero-wait memory: one response every 4 cycles.

## Test plan
- Store then load: push {1, 0x100, 0xDEADBEEF}, then {0, 0x100, 0}. Memory model returns gnt at once and rvalid 1 cycle later with 0xDEADBEEF. Required: two responses in order, (rsp_is_wr=1, rsp_data=0, rsp_err=0) then (0, 0xDEADBEEF, 0); txn_count=2.
- Misaligned: push {0, 0x102, 0}. Required: rsp_valid 1 cycle after pop with rsp_err=1, no mem_req ever asserted.
- Grant stall + backpressure: hold mem_gnt low 5 cycles and hold rsp_ready low 3 cycles after rsp_valid. Required: mem_addr/mem_we stable through the stall; rsp_* stable through backpressure; exactly one pop.
- Timeout: TIMEOUT=16, memory never sends rvalid. Required: rsp_err=1, rsp_data=0 exactly 16 cycles after gnt. Repeat with rvalid on the expiry cycle: required rsp_err=0.
- Reset mid-WAIT: assert rst for 1 cycle in WAIT, then send rvalid. Required: all outputs at reset values, no response produced, next FIFO entry processed normally.
- FIFO drain: push 4 requests into a full FIFO with rsp_ready=1. Required: 4 pops, 4 in-order responses, fifo_rd_en never high while fifo_empty=1; txn_count wraps from 0xFFFF to 0 when preloaded near its limit.

Source files
------------

// File: rtl/lsu_request_engine.sv
// Consumer end of the load-store request FIFO: pops one request, checks alignment,
// drives a req/gnt + rvalid memory port and returns one response per request, in order.
module lsu_request_engine #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REQ_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [REQ_WIDTH-1:0]  fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_is_wr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  txn_count
);

  localparam int unsigned TmoW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_is_wr_q, rsp_is_wr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  txn_q, txn_d;
  logic                  tmo_expire;

  // The counter is cleared on grant, so its next value hits TIMEOUT-1 on the last WAIT cycle.
  assign tmo_expire = (tmo_q == TmoW'(TIMEOUT - 2));

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_is_wr_d = rsp_is_wr_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;
    txn_d       = txn_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          wr_d        = fifo_rd_data[REQ_WIDTH-1];
          addr_d      = fifo_rd_data[DATA_WIDTH +: ADDR_WIDTH];
          wdata_d     = fifo_rd_data[DATA_WIDTH-1:0];
          rsp_is_wr_d = fifo_rd_data[REQ_WIDTH-1];
          if (fifo_rd_data[DATA_WIDTH +: 2] != 2'b00) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (mem_gnt) begin
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        tmo_d = tmo_q + TmoW'(1);
        // A completion on the expiry cycle still counts as success.
        if (mem_rvalid) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = wr_q ? '0 : mem_rdata;
          state_d    = StResp;
        end else if (tmo_expire) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          txn_d   = txn_q + CNT_WIDTH'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_is_wr_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
      txn_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_is_wr_q <= rsp_is_wr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
      txn_q       <= txn_d;
    end
  end

  // Show-ahead FIFO: the pop and the latch of its head happen in the same IDLE cycle.
  assign fifo_rd_en = (state_q == StIdle) && !fifo_empty && !rst;
  assign mem_req    = (state_q == StIssue);
  assign mem_we     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_is_wr  = rsp_is_wr_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != StIdle);
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_lsu_request_engine.sv
// Directed and randomized bench for lsu_request_engine against a cycle-count and
// memory-array reference model; a second instance with a 3-bit counter exercises wrap.
module tb_lsu_request_engine;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned RW  = 1 + AW + DW;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [RW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          rsp_valid, rsp_ready, rsp_is_wr, rsp_err, busy;
  logic [DW-1:0] rsp_data;
  logic [15:0]   txn_count;

  logic          s_fifo_rd_en, s_mem_req, s_mem_we, s_rsp_valid, s_rsp_is_wr, s_rsp_err, s_busy;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata, s_rsp_data;
  logic [2:0]    s_txn_count;

  int n_chk   = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  logic [RW-1:0] fifo_q[$];
  logic [DW-1:0] mem_m[logic [AW-1:0]];

  always #5 clk = ~clk;

  lsu_request_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_wr(rsp_is_wr), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .txn_count(txn_count)
  );

  lsu_request_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .CNT_WIDTH(3)) dut_small (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(s_fifo_rd_en), .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_is_wr(s_rsp_is_wr),
    .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .busy(s_busy), .txn_count(s_txn_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    fifo_q.push_back({wr, a, wd});
    upd_fifo();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_is_wr"}, 64'(rsp_is_wr), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_txn"}, 64'(txn_count), 64'd0);
    chk({tag, "_s_txn"}, 64'(s_txn_count), 64'd0);
  endtask

  task automatic chk_rsp(input logic ewr, input logic [DW-1:0] ed, input logic ee);
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_is_wr", 64'(rsp_is_wr), 64'(ewr));
    chk("rsp_data", 64'(rsp_data), 64'(ed));
    chk("rsp_err", 64'(rsp_err), 64'(ee));
    chk("rsp_no_req", 64'(mem_req), 64'd0);
    chk("rsp_no_pop", 64'(fifo_rd_en), 64'd0);
    chk("rsp_busy", 64'(busy), 64'd1);
  endtask

  // Entered in the drive phase of an IDLE cycle with the request at the FIFO head.
  // gw: cycles of gnt stall; rw: rvalid this many cycles after gnt (>= TMO means never);
  // dw: cycles of rsp_ready backpressure.
  task automatic serve(input int gw, input int rw, input int dw);
    logic [RW-1:0] e;
    logic          wr, ee;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, ed;
    e  = fifo_q[0];
    wr = e[RW-1];
    a  = e[DW +: AW];
    wd = e[DW-1:0];
    @(negedge clk);
    chk("pop", 64'(fifo_rd_en), 64'd1);
    chk("pop_not_empty", 64'(fifo_rd_en && fifo_empty), 64'd0);
    chk("pop_idle", 64'(busy), 64'd0);
    chk("pop_no_req", 64'(mem_req), 64'd0);
    chk("txn", 64'(txn_count), 64'(exp_cnt % 65536));
    chk("s_txn", 64'(s_txn_count), 64'(exp_cnt % 8));
    step();
    void'(fifo_q.pop_front());
    upd_fifo();
    if (a[1:0] != 2'b00) begin
      ee = 1'b1;
      ed = '0;
    end else begin
      for (int i = 0; i <= gw; i++) begin
        mem_gnt    = (i == gw);
        mem_rvalid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("issue_req", 64'(mem_req), 64'd1);
        chk("issue_addr", 64'(mem_addr), 64'(a));
        chk("issue_we", 64'(mem_we), 64'(wr));
        chk("issue_wdata", 64'(mem_wdata), 64'(wd));
        chk("issue_no_pop", 64'(fifo_rd_en), 64'd0);
        step();
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rw < TMO) begin
        for (int k = 1; k < rw; k++) begin
          mem_rdata = $urandom;
          @(negedge clk);
          chk("wait_no_rsp", 64'(rsp_valid), 64'd0);
          chk("wait_no_req", 64'(mem_req), 64'd0);
          step();
        end
        if (wr) begin
          mem_m[a]  = wd;
          ed        = '0;
          mem_rdata = $urandom;
        end else begin
          if (!mem_m.exists(a)) mem_m[a] = $urandom;
          ed        = mem_m[a];
          mem_rdata = ed;
        end
        ee         = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        chk("rvalid_no_rsp", 64'(rsp_valid), 64'd0);
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end else begin
        for (int k = 1; k < TMO; k++) begin
          @(negedge clk);
          chk("tmo_no_rsp", 64'(rsp_valid), 64'd0);
          step();
        end
        ee = 1'b1;
        ed = '0;
      end
    end
    for (int i = 0; i < dw; i++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      chk_rsp(wr, ed, ee);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk_rsp(wr, ed, ee);
    step();
    rsp_ready = 1'b0;
    exp_cnt++;
  endtask

  initial begin
    logic [AW-1:0] ra;
    rst = 1'b1; fifo_empty = 1'b1; fifo_rd_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    step();

    // Store then load to the same word.
    push(1'b1, 32'h100, 32'hDEADBEEF);
    push(1'b0, 32'h100, 32'h0);
    serve(0, 1, 0);
    serve(0, 1, 0);
    @(negedge clk);
    chk("st_ld_txn", 64'(txn_count), 64'd2);
    step();

    // Misaligned load: no memory access.
    push(1'b0, 32'h102, 32'h0);
    serve(0, 1, 0);

    // Grant stall and response backpressure.
    push(1'b1, 32'h40, 32'h12345678);
    serve(5, 2, 3);

    // Timeout, then rvalid on the expiry cycle.
    push(1'b0, 32'h80, 32'h0);
    serve(0, 16, 1);
    push(1'b0, 32'h100, 32'h0);
    serve(0, 15, 0);

    // Reset while waiting for completion.
    push(1'b0, 32'h100, 32'h0);
    @(negedge clk);
    chk("rw_pop", 64'(fifo_rd_en), 64'd1);
    step();
    void'(fifo_q.pop_front());
    upd_fifo();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk_reset_vals("rst_wait");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    step();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rvalid_no_rsp", 64'(rsp_valid), 64'd0);
      chk("late_rvalid_idle", 64'(busy), 64'd0);
      step();
    end
    push(1'b0, 32'h100, 32'h0);
    serve(0, 1, 0);

    // Drain four queued requests back to back.
    for (int i = 0; i < 4; i++) push(1'(i % 2), 32'h300 + 32'(i) * 4, $urandom);
    for (int i = 0; i < 4; i++) serve(0, 1, 0);
    @(negedge clk);
    chk("drain_empty", 64'(fifo_empty), 64'd1);
    chk("drain_no_pop", 64'(fifo_rd_en), 64'd0);
    step();

    // Randomized mix.
    for (int n = 0; n < 30; n++) begin
      int burst;
      burst = $urandom_range(1, 3);
      for (int b = 0; b < burst; b++) begin
        ra = 32'h200 + 32'($urandom_range(0, 7)) * 4;
        if ($urandom_range(0, 7) == 0) ra = ra + 32'($urandom_range(1, 3));
        push(1'($urandom_range(0, 1)), ra, $urandom);
      end
      for (int b = 0; b < burst; b++)
        serve($urandom_range(0, 3), $urandom_range(1, 17), $urandom_range(0, 2));
    end

    @(negedge clk);
    chk("final_txn", 64'(txn_count), 64'(exp_cnt % 65536));
    chk("final_s_txn", 64'(s_txn_count), 64'(exp_cnt % 8));
    chk("final_idle", 64'(busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
